gate2_tt_checker: RTL and testbench

GATE2_TT_CHECKER -- requirements
Module: gate2_tt_checker

---
 rtl/gate2_tt_checker.sv | 132 +++++++++++++
 tb/tb_gate2_tt_checker.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gate2_tt_checker.sv
// gate2_tt_checker: drives the four input vectors {a,b}=00..11 into a 2-input
// gate under test and compares each response y against the EXP_TT truth table.
// Each vector is held for HOLD_CYCLES clocks, and y is sampled on the last edge
// of that hold window.
// Optional build macro TT_LOOP_EN: if start is still high when vector 3 is
// sampled, the sweep wraps back to vector 0 instead of stopping. In that case
// done/pass pulse once per completed pass.
//
// state | meaning
// IDLE  | waiting for start after reset
// DRIVE | stepping through the vectors and sampling y
// DONE  | results held until the next accepted start
module gate2_tt_checker #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [3:0]  EXP_TT      = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  // Register bank. Every output comes straight from one of these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state logic: sequencing, sampling and result accumulation.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        // done/pass are only high for the single cycle after a pass completes.
        done_d = 1'b0;
        pass_d = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          cnt_d = 4'd0;
          if (y != EXP_TT[vec_q]) begin
            // Saturate at 7 so a long looping run cannot wrap the count to 0.
            err_d         = (err_q == 3'd7) ? err_q : err_q + 3'd1;
            fail_d[vec_q] = 1'b1;
          end
          if (vec_q == 2'd3) begin
            vec_d  = 2'd0;
            done_d = 1'b1;
            pass_d = (err_d == 3'd0);
`ifdef TT_LOOP_EN
            if (!start) begin
              state_d = DONE;
              busy_d  = 1'b0;
            end
`else
            state_d = DONE;
            busy_d  = 1'b0;
`endif
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate2_tt_checker.sv
// Directed bench for gate2_tt_checker with default parameters
// (HOLD_CYCLES=4, EXP_TT=AND). The response model is selected by mode.
module tb_gate2_tt_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       y;
  logic       a, b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  int mode;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Gate models: 0 = AND, 1 = stuck-at-0, 2 = OR, 3 = stuck-at-1.
  always_comb begin
    case (mode)
      0:       y = a & b;
      1:       y = 1'b0;
      2:       y = a | b;
      default: y = 1'b1;
    endcase
  end

  gate2_tt_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .y         (y),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start for one edge (edge 0), then follow the 16 edges of the run.
  // With repulse set, start is raised again for edges 3 and 7.
  task automatic do_run(input int repulse);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    check("busy_e0", int'(busy), 1);
    check("ab_e0", int'({a, b}), 0);
    check("done_e0", int'(done), 0);
    check("err_e0", int'(err_count), 0);
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk);
      @(negedge clk);
      start = (repulse != 0 && (j == 2 || j == 6)) ? 1'b1 : 1'b0;
      check("ab_step", int'({a, b}), (j < 16) ? j / 4 : 0);
      check("busy_step", int'(busy), (j < 16) ? 1 : 0);
      check("done_step", int'(done), (j == 16) ? 1 : 0);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input int exp_pass, input int exp_err, input int exp_fail);
    check("pass", int'(pass), exp_pass);
    check("err_count", int'(err_count), exp_err);
    check("fail_vec", int'(fail_vec), exp_fail);
  endtask

  initial begin
    mode  = 0;
    start = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_ab", int'({a, b}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_fail", int'(fail_vec), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Correct AND gate: clean pass, results held in DONE.
    mode = 0;
    do_run(0);
    check_result(1, 0, 0);
    repeat (3) @(negedge clk);
    check("hold_done", int'(done), 1);
    check_result(1, 0, 0);

    // Stuck-at-0: only vector 3 mismatches.
    mode = 1;
    do_run(0);
    check_result(0, 1, 4'b1000);

    // OR gate: vectors 1 and 2 mismatch.
    mode = 2;
    do_run(0);
    check_result(0, 2, 4'b0110);

    // Reset at edge 9 of an OR run, after vector 1 has already mismatched.
    mode = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_ab", int'({a, b}), 2);
    check("pre_rst_err", int'(err_count), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ab", int'({a, b}), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_err", int'(err_count), 0);
    check("mid_rst_fail", int'(fail_vec), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_done", int'(done), 0);
    mode = 0;
    do_run(0);
    check_result(1, 0, 0);

    // start re-pulsed at edges 3 and 7 must not disturb the sweep.
    mode = 0;
    do_run(1);
    check_result(1, 0, 0);

`ifdef TT_LOOP_EN
    // Looping: start high for edges 0..39, y stuck-at-1 (vectors 0,1,2 fail).
    mode = 3;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 48; j++) begin
      @(posedge clk);
      @(negedge clk);
      start = (j <= 38) ? 1'b1 : 1'b0;
      check("loop_done", int'(done), (j == 16 || j == 32 || j == 48) ? 1 : 0);
      if (j == 16) check("loop_err16", int'(err_count), 3);
      if (j == 32) check("loop_err32", int'(err_count), 6);
      if (j == 40) check("loop_err40", int'(err_count), 7);
    end
    check("loop_busy", int'(busy), 0);
    check_result(0, 7, 4'b0111);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
